microp_keys_pio: RTL

//  Avalon-MM input PIO for the MicroP system. It is the read-side counterpart of the LED output port.
//  - Samples external push-buttons/switches on in_port, synchronises and debounces each bit.
//  - Latches per-bit edge events and raises a level irq to the Nios II when an unmasked edge is pending.
//  - Sits on the system Avalon bus as slave s1, zero wait states, read latency 0.

---
 rtl/microp_keys_pio_if.sv | 22 ++
 rtl/microp_keys_pio.sv | 134 +++++++++++++
 2 files changed

// File: rtl/microp_keys_pio_if.sv
`timescale 1ns/1ps
// Avalon-MM slave bus bundle for the MicroP key/switch input PIO (slave s1).
// Signals: address (word), chipselect, write_n, writedata -> slave;
//          readdata (combinational, read latency 0), irq (level, active-high) -> master.
interface microp_keys_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/microp_keys_pio.sv
`timescale 1ns/1ps
// Avalon-MM input PIO: synchronises and debounces in_port, latches edge events, raises a masked level irq.
// Latency: in_port step -> debounced data 2+DEBOUNCE_CYCLES clocks; edge capture one clock later; reads are combinational.
// Backpressure: none; zero wait states, every access completes in the cycle it is presented.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   in_port  asynchronous external inputs (buttons/switches, active-low idle-high by default)
//   s1       Avalon-MM slave bus (address/chipselect/write_n/writedata in, readdata/irq out)
//
// Register map (word address): 0 debounced data (RO), 1 reserved (reads 0),
//                              2 irq mask (RW), 3 edge capture (read, write-1-to-clear).
module microp_keys_pio #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IDLE_VALUE      = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    microp_keys_pio_if.slave s1
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic             w_wr;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;

    // Two-flop synchroniser; reset to the idle level so no phantom edge appears after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= IDLE_VALUE;
            r_sync <= IDLE_VALUE;
        end else begin
            r_meta <= in_port;
            r_sync <= r_meta;
        end
    end

    // Per-bit debounce: a change is accepted only after it has been stable for
    // DEBOUNCE_CYCLES consecutive clocks; any return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb <= IDLE_VALUE;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_sync[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Delayed copy for edge detection; reset alongside r_deb so reset never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_d <= IDLE_VALUE;
        end else begin
            r_deb_d <= r_deb;
        end
    end

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_event = ~r_deb_d & r_deb;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_event = r_deb_d & ~r_deb;
        end else begin : g_any
            assign w_event = r_deb_d ^ r_deb;
        end
    endgenerate

    assign w_wr  = s1.chipselect & ~s1.write_n;
    assign w_clr = (w_wr && s1.address == 2'd3) ? s1.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
        end else if (w_wr && s1.address == 2'd2) begin
            r_irq_mask <= s1.writedata[WIDTH-1:0];
        end
    end

    // Clear first, then OR in new events: an event arriving with its own clear stays latched.
    // The mask is deliberately not applied here so masked events remain visible to software.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_event;
        end
    end

    always_comb begin
        s1.readdata = '0;
        case (s1.address)
            2'd0:    s1.readdata[WIDTH-1:0] = r_deb;
            2'd2:    s1.readdata[WIDTH-1:0] = r_irq_mask;
            2'd3:    s1.readdata[WIDTH-1:0] = r_edge_cap;
            default: s1.readdata = '0;
        endcase
    end

    assign s1.irq = |(r_edge_cap & r_irq_mask);

    // Upper write-data bits have no storage behind them.
    generate
        if (WIDTH < 32) begin : g_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^s1.writedata[31:WIDTH];
        end
    endgenerate

endmodule
